// File: rtl/command_executor_pkg.sv
// Shared types and defaults for the terminal command executor.
package command_executor_pkg;

    // Decoded command kinds delivered by the escape-sequence parser.
    typedef enum logic [3:0] {
        INPUT,
        IND,
        NEL,
        RI,
        CUU,
        CUD,
        CUF,
        CUB,
        CUP
    } CommandsType;

    // Executor sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } ExecState;

    localparam int unsigned COLS_DEF  = 80;
    localparam int unsigned ROWS_DEF  = 25;
    localparam logic [7:0]  BLANK_DEF = 8'h20;

    // Cursor-move repeat count: a zero parameter means "move by one".
    function automatic logic [8:0] step_count(logic [7:0] pn);
        return (pn == 8'd0) ? 9'd1 : {1'b0, pn};
    endfunction

endpackage

// File: rtl/command_executor_line_clear_engine.sv
// Writes the blank character across one physical text row, one column per cycle.
module line_clear_engine
    import command_executor_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter logic [7:0]  BLANK  = BLANK_DEF,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        phys_row,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(COLS + 1);

    logic             active;
    logic [CNT_W-1:0] cnt;   // number of columns already issued

    // High in the cycle the last column write is presented on the port.
    assign done = active && (cnt == CNT_W'(COLS));

    // Walk the row; write port registers keep their last value once finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active    <= 1'b0;
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'h00;
        end else if (start) begin
            active    <= 1'b1;
            cnt       <= CNT_W'(1);
            ram_we    <= 1'b1;
            ram_addr  <= ADDR_W'(phys_row) * ADDR_W'(COLS);
            ram_wdata <= BLANK;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                ram_we <= 1'b0;
            end else begin
                cnt      <= cnt + CNT_W'(1);
                ram_addr <= ram_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/command_executor.sv
// Applies parsed terminal commands to the text screen: cursor, circular scroll, text RAM writes.
module command_executor
    import command_executor_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter logic [7:0]  BLANK  = BLANK_DEF,
    parameter int unsigned ADDR_W = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  CommandsType       cmd_type,
    input  logic [7:0]        pn1,
    input  logic [7:0]        pn2,
    input  logic [7:0]        pchar,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic [4:0]        cursor_row,
    output logic [6:0]        cursor_col,
    output logic [4:0]        scroll_top,
    output logic              busy,
    output logic              overflow
);

    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
    localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
    localparam logic [8:0] ROW_LAST9 = 9'(ROWS - 1);
    localparam logic [8:0] COL_LAST9 = 9'(COLS - 1);

    ExecState state;

    logic [4:0] row_q, top_q;
    logic [6:0] col_q;

    // One-entry holding slot for commands arriving while not idle.
    logic        pend_valid;
    CommandsType pend_type;
    logic [7:0]  pend_pn1, pend_pn2, pend_char;

    // Character-write path and clear bookkeeping.
    logic              exec_we_q;
    logic [ADDR_W-1:0] exec_addr_q;
    logic [7:0]        exec_wdata_q;
    logic              sel_clr_q;   // clear engine owns the RAM port (last writer)
    logic              clr_pend_q;
    logic [4:0]        clr_row_q;

    // Next-state results of the command being executed this cycle.
    logic        exec_go;
    CommandsType sel_type;
    logic [7:0]  sel_pn1, sel_pn2, sel_char;
    logic [8:0]  n, r9, c9, p_row9, p_col9;
    logic [5:0]  sum6;
    logic [4:0]  phys;
    logic [ADDR_W-1:0] wr_addr;
    logic [4:0]  nxt_row, nxt_top, clr_row_nxt;
    logic [6:0]  nxt_col;
    logic        do_write, do_clear, line_feed, rev_feed;

    logic              clr_start, clr_we, clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic [7:0]        clr_wdata;

    // A pending command has priority over a fresh strobe when idle.
    always_comb begin
        exec_go  = (state == IDLE) && (pend_valid || cmd_valid);
        sel_type = pend_valid ? pend_type : cmd_type;
        sel_pn1  = pend_valid ? pend_pn1  : pn1;
        sel_pn2  = pend_valid ? pend_pn2  : pn2;
        sel_char = pend_valid ? pend_char : pchar;
    end

    // Operand preparation and cursor-to-physical address mapping.
    always_comb begin
        n       = step_count(sel_pn1);
        r9      = {4'd0, row_q};
        c9      = {2'd0, col_q};
        p_row9  = (sel_pn1 == 8'd0) ? 9'd0 : {1'b0, sel_pn1} - 9'd1;
        p_col9  = (sel_pn2 == 8'd0) ? 9'd0 : {1'b0, sel_pn2} - 9'd1;
        sum6    = {1'b0, row_q} + {1'b0, top_q};
        phys    = (sum6 >= 6'(ROWS)) ? 5'(sum6 - 6'(ROWS)) : sum6[4:0];
        wr_addr = ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col_q);
    end

    // Command semantics: new cursor/scroll and whether a write or line clear follows.
    always_comb begin
        nxt_row     = row_q;
        nxt_col     = col_q;
        nxt_top     = top_q;
        do_write    = 1'b0;
        do_clear    = 1'b0;
        clr_row_nxt = top_q;
        line_feed   = 1'b0;
        rev_feed    = 1'b0;
        case (sel_type)
            CUU: nxt_row = (r9 < n) ? 5'd0 : 5'(r9 - n);
            CUD: nxt_row = ((r9 + n) > ROW_LAST9) ? ROW_LAST : 5'(r9 + n);
            CUF: nxt_col = ((c9 + n) > COL_LAST9) ? COL_LAST : 7'(c9 + n);
            CUB: nxt_col = (c9 < n) ? 7'd0 : 7'(c9 - n);
            CUP: begin
                nxt_row = (p_row9 > ROW_LAST9) ? ROW_LAST : 5'(p_row9);
                nxt_col = (p_col9 > COL_LAST9) ? COL_LAST : 7'(p_col9);
            end
            IND: line_feed = 1'b1;
            NEL: begin
                line_feed = 1'b1;
                nxt_col   = 7'd0;
            end
            RI:  rev_feed = 1'b1;
            INPUT: begin
                if (sel_char == 8'h0D) begin
                    nxt_col = 7'd0;
                end else if (sel_char == 8'h08) begin
                    nxt_col = (col_q == 7'd0) ? 7'd0 : col_q - 7'd1;
                end else if (sel_char == 8'h0A) begin
                    line_feed = 1'b1;
                end else if (sel_char >= 8'h20) begin
                    do_write = 1'b1;
                    if (col_q < COL_LAST) begin
                        nxt_col = col_q + 7'd1;
                    end else begin
                        nxt_col   = 7'd0;
                        line_feed = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (line_feed) begin
            if (row_q < ROW_LAST) begin
                nxt_row = row_q + 5'd1;
            end else begin
                // Oldest physical row becomes the new bottom line.
                nxt_top     = (top_q == ROW_LAST) ? 5'd0 : top_q + 5'd1;
                do_clear    = 1'b1;
                clr_row_nxt = top_q;
            end
        end
        if (rev_feed) begin
            if (row_q != 5'd0) begin
                nxt_row = row_q - 5'd1;
            end else begin
                nxt_top     = (top_q == 5'd0) ? ROW_LAST : top_q - 5'd1;
                do_clear    = 1'b1;
                clr_row_nxt = (top_q == 5'd0) ? ROW_LAST : top_q - 5'd1;
            end
        end
    end

    // Command intake, execution sequencing and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            row_q        <= 5'd0;
            col_q        <= 7'd0;
            top_q        <= 5'd0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            pend_valid   <= 1'b0;
            pend_type    <= INPUT;
            pend_pn1     <= 8'h00;
            pend_pn2     <= 8'h00;
            pend_char    <= 8'h00;
            exec_we_q    <= 1'b0;
            exec_addr_q  <= '0;
            exec_wdata_q <= 8'h00;
            sel_clr_q    <= 1'b0;
            clr_pend_q   <= 1'b0;
            clr_row_q    <= 5'd0;
        end else begin
            if (state == IDLE) begin
                // Slot drains this cycle; a simultaneous strobe refills it.
                if (pend_valid) begin
                    pend_valid <= cmd_valid;
                    if (cmd_valid) begin
                        pend_type <= cmd_type;
                        pend_pn1  <= pn1;
                        pend_pn2  <= pn2;
                        pend_char <= pchar;
                    end
                end
            end else if (cmd_valid) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_type  <= cmd_type;
                    pend_pn1   <= pn1;
                    pend_pn2   <= pn2;
                    pend_char  <= pchar;
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    exec_we_q <= 1'b0;
                    if (exec_go) begin
                        row_q      <= nxt_row;
                        col_q      <= nxt_col;
                        top_q      <= nxt_top;
                        exec_we_q  <= do_write;
                        clr_pend_q <= do_clear;
                        clr_row_q  <= clr_row_nxt;
                        if (do_write) begin
                            exec_addr_q  <= wr_addr;
                            exec_wdata_q <= sel_char;
                            sel_clr_q    <= 1'b0;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    exec_we_q  <= 1'b0;
                    clr_pend_q <= 1'b0;
                    if (clr_pend_q) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        sel_clr_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clr_start = (state == EXEC) && clr_pend_q;

    line_clear_engine #(
        .COLS   (COLS),
        .BLANK  (BLANK),
        .ADDR_W (ADDR_W)
    ) u_line_clear (
        .clk       (clk),
        .rst       (rst),
        .start     (clr_start),
        .phys_row  (clr_row_q),
        .ram_we    (clr_we),
        .ram_addr  (clr_addr),
        .ram_wdata (clr_wdata),
        .done      (clr_done)
    );

    // RAM port follows whichever path wrote last so address/data hold when idle.
    assign ram_we     = exec_we_q | clr_we;
    assign ram_addr   = sel_clr_q ? clr_addr  : exec_addr_q;
    assign ram_wdata  = sel_clr_q ? clr_wdata : exec_wdata_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign scroll_top = top_q;

endmodule

// File: tb/tb_command_executor.sv
// Scoreboard bench: expected RAM writes are queued by stimulus and checked by a monitor.
module tb_command_executor;
    import command_executor_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    CommandsType cmd_type = INPUT;
    logic [7:0]  pn1 = 8'h00, pn2 = 8'h00, pchar = 8'h00;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [4:0]  cursor_row, scroll_top;
    logic [6:0]  cursor_col;
    logic        busy, overflow;

    command_executor dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .pn1        (pn1),
        .pn2        (pn2),
        .pchar      (pchar),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .scroll_top (scroll_top),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  busy_cnt = 0;

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (rst && busy) busy_cnt++;
        if (rst && ram_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %h, no write expected",
                         ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                if (ram_addr !== e.addr || ram_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL ram_write: got addr %0d data %h, expected addr %0d data %h",
                             ram_addr, ram_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_cur(input string name, input int r, input int c, input int t);
        chk({name, "_row"}, 32'(cursor_row), 32'(r));
        chk({name, "_col"}, 32'(cursor_col), 32'(c));
        chk({name, "_top"}, 32'(scroll_top), 32'(t));
    endtask

    task automatic exp_wr(input int addr, input int data);
        wr_t e;
        e.addr = 11'(addr);
        e.data = 8'(data);
        exp_q.push_back(e);
    endtask

    task automatic exp_clear(input int prow);
        for (int i = 0; i < 80; i++) exp_wr(prow * 80 + i, 8'h20);
    endtask

    // Returns in the cycle where the command's results are visible.
    task automatic send(input CommandsType t, input int a, input int b, input int ch);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = t;
        pn1       = 8'(a);
        pn2       = 8'(b);
        pchar     = 8'(ch);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: got busy 1 expected 0 within 300 cycles");
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_we"},    32'(ram_we), 0);
        chk({name, "_addr"},  32'(ram_addr), 0);
        chk({name, "_wdata"}, 32'(ram_wdata), 0);
        chk({name, "_busy"},  32'(busy), 0);
        chk({name, "_ovf"},   32'(overflow), 0);
        chk_cur(name, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        exp_wr(0, 8'h41);
        send(INPUT, 0, 0, 8'h41);
        chk_cur("input_A", 0, 1, 0);

        send(CUP, 5, 10, 0);    chk_cur("cup_5_10", 4, 9, 0);
        send(CUP, 0, 200, 0);   chk_cur("cup_0_200", 0, 79, 0);
        send(CUP, 4, 10, 0);    chk_cur("cup_4_10", 3, 9, 0);
        send(CUU, 0, 0, 0);     chk_cur("cuu_0", 2, 9, 0);
        send(CUU, 50, 0, 0);    chk_cur("cuu_50", 0, 9, 0);
        send(CUF, 90, 0, 0);    chk_cur("cuf_90", 0, 79, 0);
        send(CUD, 3, 0, 0);     chk_cur("cud_3", 3, 79, 0);
        send(CUB, 5, 0, 0);     chk_cur("cub_5", 3, 74, 0);
        send(INPUT, 0, 0, 8'h08); chk_cur("bs", 3, 73, 0);
        send(INPUT, 0, 0, 8'h0D); chk_cur("cr", 3, 0, 0);
        send(INPUT, 0, 0, 8'h01); chk_cur("ctrl_ignored", 3, 0, 0);
        send(INPUT, 0, 0, 8'h0A); chk_cur("lf", 4, 0, 0);
        exp_wr(320, 8'h62);
        send(INPUT, 0, 0, 8'h62); chk_cur("input_b", 4, 1, 0);

        // Character at the bottom-right corner wraps and scrolls the screen up.
        send(CUP, 25, 80, 0);   chk_cur("cup_corner", 24, 79, 0);
        exp_wr(24 * 80 + 79, 8'h5A);
        exp_clear(0);
        busy_cnt = 0;
        send(INPUT, 0, 0, 8'h5A);
        chk_cur("wrap_scroll", 24, 0, 1);
        wait_idle();
        chk("wrap_busy_cycles", 32'(busy_cnt), 80);
        chk_cur("wrap_after", 24, 0, 1);

        send(CUP, 1, 1, 0);     chk_cur("cup_home", 0, 0, 1);
        exp_wr(80, 8'h63);
        send(INPUT, 0, 0, 8'h63); chk_cur("input_c", 0, 1, 1);

        exp_clear(0);
        send(RI, 0, 0, 0);
        wait_idle();
        chk_cur("ri_top1", 0, 1, 0);
        exp_clear(24);
        send(RI, 0, 0, 0);
        wait_idle();
        chk_cur("ri_top0", 0, 1, 24);
        exp_wr(1921, 8'h64);
        send(INPUT, 0, 0, 8'h64); chk_cur("input_d", 0, 2, 24);
        send(NEL, 0, 0, 0);     chk_cur("nel", 1, 0, 24);

        // Two commands during a clear: first is held, second is dropped.
        send(CUP, 1, 5, 0);     chk_cur("cup_1_5", 0, 4, 24);
        exp_clear(23);
        send(RI, 0, 0, 0);
        repeat (5) @(negedge clk);
        send(CUD, 2, 0, 0);
        send(CUF, 0, 0, 0);
        chk("held_row_mid_clear", 32'(cursor_row), 0);
        chk("busy_mid_clear", 32'(busy), 1);
        wait_idle();
        chk_cur("pending_cud", 2, 4, 23);
        chk("overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of a clear.
        send(CUP, 25, 1, 0);    chk_cur("cup_bottom", 24, 0, 23);
        exp_clear(23);
        send(IND, 0, 0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk_reset_outputs("reset_mid_clear");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_after_reset", 32'(busy), 0);
        exp_wr(0, 8'h65);
        send(INPUT, 0, 0, 8'h65); chk_cur("input_e", 0, 1, 0);
        repeat (3) @(negedge clk);

        chk("writes_outstanding", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
